// File: rtl/timer_counter.sv
// timer_counter: prescaled up/down timer with TOP wrap/reload, compare match and one-shot expiry
module timer_counter #(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_value,
  input  logic                      count_down,
  input  logic                      one_shot,
  input  logic [WIDTH-1:0]          top,
  input  logic [WIDTH-1:0]          compare,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]          value,
  output logic                      running,
  output logic                      expired,
  output logic                      wrap_pulse,
  output logic                      match_pulse
);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
  state_t                    r_state, w_state;
  logic [WIDTH-1:0]          r_value, w_value, w_step;
  logic [PRESCALE_WIDTH-1:0] r_presc, w_presc;
  logic                      r_running, r_expired, r_wrap, w_wrap, r_match, w_match;
  logic                      w_tick, w_term, w_hold;
  assign w_tick = (r_state == RUN) && (r_presc == prescale);
  assign w_term = count_down ? (r_value == '0) : (r_value == top);
  assign w_hold = w_term && one_shot;
  assign w_step = w_term ? (count_down ? top : '0) : (count_down ? r_value - WIDTH'(1) : r_value + WIDTH'(1));
  // next state, value, prescaler and pulses in priority load > stop > start > tick
  always_comb begin
    w_state = r_state;
    w_value = r_value;
    w_presc = r_presc;
    w_wrap  = 1'b0;
    w_match = 1'b0;
    if (load) begin
      w_value = load_value;
      w_presc = '0;
    end else if (stop) begin
      w_state = IDLE;
      w_presc = '0;
    end else if (start && r_state != RUN) begin
      w_state = RUN;
      w_presc = '0;
      if (r_state == EXPIRED) w_value = count_down ? top : '0;
    end else if (w_tick) begin
      w_presc = '0;
      w_wrap  = w_term;
      w_state = w_hold ? EXPIRED : RUN;
      w_value = w_hold ? r_value : w_step;
      w_match = (w_value == compare);
    end else if (r_state == RUN) begin
      w_presc = r_presc + PRESCALE_WIDTH'(1);
    end
  end
  // register everything so all outputs come straight from flops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_value   <= '0;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_wrap    <= 1'b0;
      r_match   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_value   <= w_value;
      r_presc   <= w_presc;
      r_running <= (w_state == RUN);
      r_expired <= (w_state == EXPIRED);
      r_wrap    <= w_wrap;
      r_match   <= w_match;
    end
  end
  assign value       = r_value;
  assign running     = r_running;
  assign expired     = r_expired;
  assign wrap_pulse  = r_wrap;
  assign match_pulse = r_match;
endmodule
